// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame parser: FSM states, per-frame status codes
// and default framing constants.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } frame_state_e;

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_CSUM   = 2'b01,
    ERR_PARITY = 2'b10,
    ERR_ABORT  = 2'b11
  } frame_err_e;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;
  localparam int         DEFAULT_MAX_LEN  = 64;

  // A parity error outranks a checksum mismatch when closing a frame.
  function automatic frame_err_e close_err(input logic parity_seen, input logic csum_ok);
    if (parity_seen) return ERR_PARITY;
    if (!csum_ok) return ERR_CSUM;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Payload stream and per-frame status bundle between the frame parser (master)
// and the command layer (slave).
interface uart_frame_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic                 frame_done;
  logic [1:0]           err_code;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output frame_done,
    output err_code,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    input  frame_done,
    input  err_code,
    output m_ready
  );

endinterface

// File: rtl/uart_frame_rx_timer.sv
// Inter-byte idle counter: clearable, holdable up-counter that flags the cycle
// in which the idle count reaches TIMEOUT_CYCLES.
module frame_idle_timer #(
  parameter int TIMEOUT_BITS   = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic hold,
  output logic expire
);

  localparam logic [TIMEOUT_BITS-1:0] LAST_IDLE = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_BITS-1:0] count_q;
  logic [TIMEOUT_BITS-1:0] count_d;

  // expire fires on the idle cycle that would bring the count to TIMEOUT_CYCLES
  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = count_q + TIMEOUT_BITS'(1);
      expire  = (count_q == LAST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART RX FIFO: hunts for SOF, reads LEN, streams the
// payload on a valid/ready port and reports ok/checksum/parity/abort per frame.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int                   DATA_BITS      = 8,
  parameter logic [DATA_BITS-1:0] SOF_BYTE       = DATA_BITS'(DEFAULT_SOF_BYTE),
  parameter int                   MAX_LEN        = DEFAULT_MAX_LEN,
  parameter int                   TIMEOUT_BITS   = 16,
  parameter int                   TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] r_data,
  input  logic                 rx_empty,
  input  logic                 parity_error,
  output logic                 rd_uart,
  uart_frame_rx_if.master      m
);

  localparam logic [DATA_BITS-1:0] MAX_LEN_V = DATA_BITS'(MAX_LEN);
  localparam logic [DATA_BITS-1:0] ONE_V     = DATA_BITS'(1);

  frame_state_e         state_q,      state_d;
  logic [DATA_BITS-1:0] xor_q,        xor_d;
  logic [DATA_BITS-1:0] remaining_q,  remaining_d;
  logic                 parity_q,     parity_d;
  logic [DATA_BITS-1:0] m_data_q,     m_data_d;
  logic                 m_valid_q,    m_valid_d;
  logic                 m_last_q,     m_last_d;
  logic                 frame_done_q, frame_done_d;
  frame_err_e           err_q,        err_d;

  logic byte_take;
  logic timer_clear;
  logic timer_hold;
  logic timeout;

  // Only a stalled payload beat blocks the FIFO; LEN/CHK bytes are taken even
  // while the last beat waits for the consumer.
  assign byte_take   = ~rx_empty & ((state_q != ST_PAYLOAD) | ~m_valid_q | m.m_ready);
  assign rd_uart     = byte_take;
  assign timer_clear = byte_take | (state_q == ST_HUNT);
  assign timer_hold  = m_valid_q & ~m.m_ready;

  frame_idle_timer #(
    .TIMEOUT_BITS   (TIMEOUT_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .hold    (timer_hold),
    .expire  (timeout)
  );

  always_comb begin
    state_d      = state_q;
    xor_d        = xor_q;
    remaining_d  = remaining_q;
    parity_d     = parity_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    err_d        = ERR_OK;

    if (m_valid_q && m.m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if ((state_q != ST_HUNT) && parity_error) begin
      parity_d = 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_take && (r_data == SOF_BYTE)) begin
          state_d  = ST_LEN;
          xor_d    = '0;
          parity_d = 1'b0;
        end
      end

      ST_LEN: begin
        if (byte_take) begin
          xor_d = xor_q ^ r_data;
          if (r_data > MAX_LEN_V) begin
            state_d      = ST_HUNT;
            frame_done_d = 1'b1;
            err_d        = ERR_ABORT;
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
          end else if (r_data == '0) begin
            state_d = ST_CHK;
          end else begin
            state_d     = ST_PAYLOAD;
            remaining_d = r_data;
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_take) begin
          m_data_d    = r_data;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == ONE_V);
          xor_d       = xor_q ^ r_data;
          remaining_d = remaining_q - ONE_V;
          if (remaining_q == ONE_V) begin
            state_d = ST_CHK;
          end
        end
      end

      ST_CHK: begin
        if (byte_take) begin
          state_d      = ST_HUNT;
          frame_done_d = 1'b1;
          err_d        = close_err(parity_q | parity_error, r_data == xor_q);
        end
      end

      default: state_d = ST_HUNT;
    endcase

    // Timeout never coincides with a take, so it simply overrides the FSM.
    if (timeout) begin
      state_d      = ST_HUNT;
      frame_done_d = 1'b1;
      err_d        = ERR_ABORT;
      m_valid_d    = 1'b0;
      m_last_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HUNT;
      xor_q        <= '0;
      remaining_q  <= '0;
      parity_q     <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= ERR_OK;
    end else begin
      state_q      <= state_d;
      xor_q        <= xor_d;
      remaining_q  <= remaining_d;
      parity_q     <= parity_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign m.m_data     = m_data_q;
  assign m.m_valid    = m_valid_q;
  assign m.m_last     = m_last_q;
  assign m.frame_done = frame_done_q;
  assign m.err_code   = err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: a FIFO model feeds bytes, a stream-level
// frame parser predicts beats and statuses, and a monitor checks them.
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int         TO_CYCLES = 100;
  localparam int         MAXL      = 64;
  localparam logic [7:0] SOF       = 8'hA5;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       parity_error;
  logic       rd_uart;

  uart_frame_rx_if #(.DATA_BITS(8)) mif ();

  uart_frame_rx #(
    .DATA_BITS      (8),
    .SOF_BYTE       (SOF),
    .MAX_LEN        (MAXL),
    .TIMEOUT_BITS   (16),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r_data       (r_data),
    .rx_empty     (rx_empty),
    .parity_error (parity_error),
    .rd_uart      (rd_uart),
    .m            (mif)
  );

  always #5 clk = ~clk;

  logic [7:0] rxBytes[$];
  bit         rxTags[$];
  logic [7:0] stageBytes[$];
  bit         stageTags[$];
  logic [7:0] seqQ[$];
  beat_t      expBeats[$];
  logic [1:0] expDone[$];

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int popCount = 0;
  int lastTakeCycle = 0;
  int lastDoneCycle = 0;
  int doneCount = 0;
  int gapPct = 0;
  int readyMode = 1;
  bit forceParity = 1'b0;

  // FIFO model: presents the head byte first-word-fall-through, pops on rd_uart
  initial begin
    bit took;
    rx_empty = 1'b1;
    r_data = 8'h00;
    parity_error = 1'b0;
    mif.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rxBytes.size() > 0 && $urandom_range(99) >= gapPct) begin
        rx_empty = 1'b0;
        r_data = rxBytes[0];
        parity_error = rxTags[0] | forceParity;
      end else begin
        rx_empty = 1'b1;
        r_data = 8'($urandom);
        parity_error = forceParity;
      end
      case (readyMode)
        0: mif.m_ready = ($urandom_range(3) != 0);
        1: mif.m_ready = 1'b1;
        default: mif.m_ready = 1'b0;
      endcase
      #4;
      took = rd_uart;
      @(posedge clk);
      cycleCount++;
      if (took) begin
        checks++;
        if (rx_empty) begin
          failures++;
          $display("[TB] FAIL pop_on_empty: rd_uart=1 while rx_empty=1 at cycle %0d", cycleCount);
        end else begin
          void'(rxBytes.pop_front());
          void'(rxTags.pop_front());
          popCount++;
          lastTakeCycle = cycleCount;
        end
      end
    end
  end

  // Monitor: compares every accepted beat and every frame_done against the queues
  initial begin
    beat_t e;
    bit prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
        prevDone = 1'b0;
      end else begin
        if (mif.m_valid && mif.m_ready) begin
          checks++;
          if (expBeats.size() == 0) begin
            failures++;
            $display("[TB] FAIL beat: unexpected beat data=%h last=%b", mif.m_data, mif.m_last);
          end else begin
            e = expBeats.pop_front();
            if (mif.m_data !== e.data || mif.m_last !== e.last) begin
              failures++;
              $display("[TB] FAIL beat: got data=%h last=%b, expected data=%h last=%b",
                       mif.m_data, mif.m_last, e.data, e.last);
            end
          end
        end
        if (mif.frame_done) begin
          doneCount++;
          lastDoneCycle = cycleCount;
          checks++;
          if (prevDone) begin
            failures++;
            $display("[TB] FAIL done_pulse: frame_done high two cycles in a row");
          end
          checks++;
          if (expDone.size() == 0) begin
            failures++;
            $display("[TB] FAIL done: unexpected frame_done err=%b", mif.err_code);
          end else begin
            logic [1:0] ee;
            ee = expDone.pop_front();
            if (mif.err_code !== ee) begin
              failures++;
              $display("[TB] FAIL done: got err=%b, expected err=%b", mif.err_code, ee);
            end
          end
        end
        prevDone = mif.frame_done;
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic stageByte(input logic [7:0] b, input bit t);
    stageBytes.push_back(b);
    stageTags.push_back(t);
  endtask

  // Reference model: parse the staged byte stream frame by frame, then hand it to the FIFO
  task automatic applyStimulus();
    int i = 0;
    int n = stageBytes.size();
    while (i < n) begin
      if (stageBytes[i] != SOF) begin
        i++;
        continue;
      end
      if (i + 1 >= n) break;
      begin
        int len = int'(stageBytes[i+1]);
        bit par = stageTags[i+1];
        logic [7:0] x = stageBytes[i+1];
        if (len > MAXL) begin
          expDone.push_back(2'b11);
          i += 2;
        end else begin
          for (int k = 0; k < len; k++) begin
            x ^= stageBytes[i+2+k];
            par |= stageTags[i+2+k];
            expBeats.push_back('{data: stageBytes[i+2+k], last: (k == len - 1)});
          end
          par |= stageTags[i+2+len];
          if (par) expDone.push_back(2'b10);
          else if (stageBytes[i+2+len] != x) expDone.push_back(2'b01);
          else expDone.push_back(2'b00);
          i += len + 3;
        end
      end
    end
    foreach (stageBytes[k]) begin
      rxBytes.push_back(stageBytes[k]);
      rxTags.push_back(stageTags[k]);
    end
    stageBytes.delete();
    stageTags.delete();
  endtask

  task automatic stageSeq();
    foreach (seqQ[k]) stageByte(seqQ[k], 1'b0);
  endtask

  task automatic sendRaw();
    foreach (seqQ[k]) begin
      rxBytes.push_back(seqQ[k]);
      rxTags.push_back(1'b0);
    end
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while ((rxBytes.size() != 0 || expBeats.size() != 0 || expDone.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rxBytes.size() != 0 || expBeats.size() != 0 || expDone.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: not drained in %0d cycles (fifo=%0d beats=%0d dones=%0d), expected all 0",
               name, limit, rxBytes.size(), expBeats.size(), expDone.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset(input string name);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    checkOutput({name, "_m_valid"}, 32'(mif.m_valid), 0);
    checkOutput({name, "_m_last"}, 32'(mif.m_last), 0);
    checkOutput({name, "_m_data"}, 32'(mif.m_data), 0);
    checkOutput({name, "_frame_done"}, 32'(mif.frame_done), 0);
    checkOutput({name, "_err_code"}, 32'(mif.err_code), 0);
    checkOutput({name, "_rd_uart"}, 32'(rd_uart), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int p0;
    int c0;
    int n;
    int sel;
    logic [7:0] b;
    logic [7:0] len;
    logic [7:0] x;

    $display("[TB] start");
    doReset("reset");

    readyMode = 1;
    gapPct = 0;

    // 1: three-beat frame with a good checksum
    p0 = popCount;
    seqQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    stageSeq();
    applyStimulus();
    waitDrain("t1", 60);
    checkOutput("t1_pops", 32'(popCount - p0), 6);

    // 2: bad checksum
    seqQ = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    stageSeq();
    applyStimulus();
    waitDrain("t2", 60);

    // 3: noise before a zero-length frame
    p0 = popCount;
    seqQ = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};
    stageSeq();
    applyStimulus();
    waitDrain("t3", 60);
    checkOutput("t3_pops", 32'(popCount - p0), 6);

    // 4: LEN just above MAX_LEN aborts, next frame parses normally
    seqQ = '{8'hA5, 8'h41, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    stageSeq();
    applyStimulus();
    waitDrain("t4", 60);

    // Largest legal frame must stream at one beat per cycle
    stageByte(SOF, 1'b0);
    stageByte(8'd64, 1'b0);
    x = 8'd64;
    for (int k = 0; k < 64; k++) begin
      b = 8'($urandom);
      x ^= b;
      stageByte(b, 1'b0);
    end
    stageByte(x, 1'b0);
    applyStimulus();
    waitDrain("len64_back_to_back", 75);

    // 5: idle timeout inside the payload
    d0 = doneCount;
    seqQ = '{8'hA5, 8'h02, 8'hAA};
    sendRaw();
    expBeats.push_back('{data: 8'hAA, last: 1'b0});
    expDone.push_back(2'b11);
    n = 0;
    while (doneCount == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_done_seen", 32'(doneCount - d0), 1);
    checkOutput("t5_timeout_latency", 32'(lastDoneCycle - lastTakeCycle), TO_CYCLES);
    @(negedge clk);
    #4;
    checkOutput("t5_m_valid_after", 32'(mif.m_valid), 0);
    checkOutput("t5_m_last_after", 32'(mif.m_last), 0);
    waitDrain("t5", 10);

    // 6: consumer stall does not time out; parity pulse wins over a good checksum
    d0 = doneCount;
    readyMode = 2;
    seqQ = '{8'hA5, 8'h01, 8'h55};
    sendRaw();
    expBeats.push_back('{data: 8'h55, last: 1'b1});
    expDone.push_back(2'b10);
    repeat (200) @(negedge clk);
    #4;
    checkOutput("t6_no_timeout", 32'(doneCount - d0), 0);
    checkOutput("t6_beat_held", 32'(mif.m_valid), 1);
    checkOutput("t6_fifo_popped", 32'(rxBytes.size()), 0);
    forceParity = 1'b1;
    repeat (2) @(negedge clk);
    forceParity = 1'b0;
    readyMode = 1;
    seqQ = '{8'h54};
    sendRaw();
    waitDrain("t6", 30);

    // 6b: stalled payload beat keeps the next byte in the FIFO
    d0 = doneCount;
    readyMode = 2;
    seqQ = '{8'hA5, 8'h02, 8'h55, 8'h66, 8'h31};
    stageSeq();
    applyStimulus();
    repeat (150) @(negedge clk);
    checkOutput("t6b_no_timeout", 32'(doneCount - d0), 0);
    checkOutput("t6b_bytes_waiting", 32'(rxBytes.size()), 2);
    readyMode = 1;
    waitDrain("t6b", 30);

    // Reset in the middle of a frame, then a clean frame
    seqQ = '{8'hA5, 8'h03, 8'h11};
    sendRaw();
    expBeats.push_back('{data: 8'h11, last: 1'b0});
    waitDrain("midreset_pre", 20);
    doReset("midreset");
    seqQ = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    stageSeq();
    applyStimulus();
    waitDrain("midreset_post", 30);

    // Randomized frames with gaps, backpressure and parity tags
    readyMode = 0;
    gapPct = 20;
    c0 = cycleCount;
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(2);
      for (int k = 0; k < n; k++) begin
        do b = 8'($urandom); while (b == SOF);
        stageByte(b, $urandom_range(7) == 0);
      end
      stageByte(SOF, $urandom_range(7) == 0);
      sel = $urandom_range(9);
      if (sel == 0) len = 8'd0;
      else if (sel == 1) len = 8'($urandom_range(65, 255));
      else if (sel == 2) len = 8'd64;
      else len = 8'($urandom_range(1, 20));
      stageByte(len, $urandom_range(15) == 0);
      if (int'(len) <= MAXL) begin
        x = len;
        for (int k = 0; k < int'(len); k++) begin
          b = 8'($urandom);
          x ^= b;
          stageByte(b, $urandom_range(31) == 0);
        end
        if ($urandom_range(3) == 0) x ^= 8'($urandom_range(1, 255));
        stageByte(x, $urandom_range(15) == 0);
      end
      applyStimulus();
    end
    waitDrain("random", 30000);
    $display("[TB] random phase used %0d cycles", cycleCount - c0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
